// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: collects PIN digits from the keypad scanner, validates them
// against the stored code and issues arm/disarm commands to the alarm FSM.
// Enforces an inter-key timeout and a lockout after repeated wrong codes.
// Optional PIN change (key 0xB) is compiled in with macro KEYPAD_PIN_CHANGE_EN.
module keypad_pin_entry #(
    parameter int PIN_LEN        = 4,
    parameter logic [4*PIN_LEN-1:0] PIN_CODE = 16'h1234,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] keypad,
    output logic       entry_active,
    output logic       locked,
    output logic       bad_code
);

    localparam int BUF_W  = 4 * PIN_LEN;
    localparam int CNT_W  = $clog2(PIN_LEN + 2);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LCK_W  = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;
    localparam logic [1:0] ST_PROGRAM = 2'd3;

    localparam logic [3:0] CMD_ARM    = 4'b0011;
    localparam logic [3:0] CMD_DISARM = 4'b1100;

    logic [1:0]        state_reg, state_next;
    logic [BUF_W-1:0]  buf_reg, buf_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [LCK_W-1:0]  lck_reg, lck_next;
    logic [FAIL_W-1:0] fail_reg, fail_next;
    logic [BUF_W-1:0]  pin_reg, pin_next;
    logic [3:0]        keypad_reg, keypad_next;
    logic              bad_reg, bad_next;

    // Key decode; a strobe with an unused code decodes to nothing at all.
    logic is_digit, is_arm, is_disarm, is_clear, is_prog, is_cmd;
    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_arm    = key_valid && (key_code == 4'hA);
    assign is_disarm = key_valid && (key_code == 4'hD);
    assign is_clear  = key_valid && (key_code == 4'hC);
`ifdef KEYPAD_PIN_CHANGE_EN
    assign is_prog   = key_valid && (key_code == 4'hB);
`else
    assign is_prog   = 1'b0;
`endif
    assign is_cmd    = is_arm || is_disarm || is_prog;

    // Entry matches only with exactly PIN_LEN digits (the count saturates one
    // above PIN_LEN so over-long entries can never match).
    logic match, timeout_hit, lock_hit;
    logic [CNT_W-1:0]  cnt_inc;
    logic [FAIL_W-1:0] fail_sat;
    assign match       = (cnt_reg == CNT_W'(PIN_LEN)) && (buf_reg == pin_reg);
    assign timeout_hit = (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1));
    assign lock_hit    = (fail_reg >= FAIL_W'(MAX_FAIL - 1));
    assign cnt_inc     = (cnt_reg == CNT_W'(PIN_LEN + 1)) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign fail_sat    = (fail_reg == FAIL_W'(MAX_FAIL)) ? fail_reg : fail_reg + FAIL_W'(1);

    // Next-state logic: key handling per state, timeout and lockout timers.
    always_comb begin
        logic reject;
        logic abort;
        state_next  = state_reg;
        buf_next    = buf_reg;
        cnt_next    = cnt_reg;
        tmo_next    = tmo_reg;
        lck_next    = lck_reg;
        fail_next   = fail_reg;
        pin_next    = pin_reg;
        keypad_next = 4'b0000;
        bad_next    = 1'b0;
        reject      = 1'b0;
        abort       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (is_digit) begin
                    buf_next   = BUF_W'(key_code);
                    cnt_next   = CNT_W'(1);
                    tmo_next   = '0;
                    state_next = ST_COLLECT;
                end else if (is_cmd) begin
                    reject = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (is_digit) begin
                    buf_next = (buf_reg << 4) | BUF_W'(key_code);
                    cnt_next = cnt_inc;
                    tmo_next = '0;
                end else if (is_clear) begin
                    buf_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (is_cmd) begin
                    if (match) begin
                        fail_next = '0;
                        buf_next  = '0;
                        cnt_next  = '0;
                        if (is_prog) begin
                            tmo_next   = '0;
                            state_next = ST_PROGRAM;
                        end else begin
                            keypad_next = is_arm ? CMD_ARM : CMD_DISARM;
                            state_next  = ST_IDLE;
                        end
                    end else begin
                        reject = 1'b1;
                    end
                end else if (timeout_hit) begin
                    buf_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
`ifdef KEYPAD_PIN_CHANGE_EN
            ST_PROGRAM: begin
                if (is_digit) begin
                    buf_next = (buf_reg << 4) | BUF_W'(key_code);
                    cnt_next = cnt_inc;
                    tmo_next = '0;
                end else if (is_prog) begin
                    if (cnt_reg == CNT_W'(PIN_LEN)) begin
                        pin_next   = buf_reg;
                        buf_next   = '0;
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (is_arm || is_disarm || is_clear) begin
                    abort = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
`endif
            ST_LOCKOUT: begin
                if (lck_reg == LCK_W'(LOCKOUT_CYCLES - 1)) begin
                    fail_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    lck_next = lck_reg + LCK_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Wrong code: count it and lock out once the limit is reached.
        if (reject) begin
            bad_next  = 1'b1;
            buf_next  = '0;
            cnt_next  = '0;
            fail_next = fail_sat;
            lck_next  = '0;
            state_next = lock_hit ? ST_LOCKOUT : ST_IDLE;
        end
        // Aborted PIN change: old PIN kept, not counted as a wrong code.
        if (abort) begin
            bad_next   = 1'b1;
            buf_next   = '0;
            cnt_next   = '0;
            state_next = ST_IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            buf_reg    <= '0;
            cnt_reg    <= '0;
            tmo_reg    <= '0;
            lck_reg    <= '0;
            fail_reg   <= '0;
            pin_reg    <= PIN_CODE;
            keypad_reg <= 4'b0000;
            bad_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buf_reg    <= buf_next;
            cnt_reg    <= cnt_next;
            tmo_reg    <= tmo_next;
            lck_reg    <= lck_next;
            fail_reg   <= fail_next;
            pin_reg    <= pin_next;
            keypad_reg <= keypad_next;
            bad_reg    <= bad_next;
        end
    end

    assign keypad       = keypad_reg;
    assign bad_code     = bad_reg;
    assign entry_active = (state_reg == ST_COLLECT) || (state_reg == ST_PROGRAM);
    assign locked       = (state_reg == ST_LOCKOUT);

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Testbench for keypad_pin_entry: directed scenarios plus random key streams,
// checked by a scoreboard fed from a digit-list reference model.
module tb_keypad_pin_entry;

    localparam int PIN_LEN = 4;
    localparam int T       = 1000;
    localparam int L       = 5000;
    localparam int MAXF    = 3;
    localparam int MAXC    = 100000;
`ifdef KEYPAD_PIN_CHANGE_EN
    localparam bit PCE = 1'b1;
`else
    localparam bit PCE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] keypad;
    logic       entry_active;
    logic       locked;
    logic       bad_code;

    keypad_pin_entry dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .keypad(keypad), .entry_active(entry_active), .locked(locked), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Expected output events: kind 1 = arm, 2 = disarm, 3 = bad_code pulse.
    typedef struct { int kind; int cyc; } ev_t;
    ev_t evq[$];
    bit exp_active[MAXC];
    bit exp_locked[MAXC];

    // Reference model: 0 idle, 1 collecting, 2 locked out, 3 programming.
    int mode = 0;
    int digs[$];
    int pin[$];
    int fails = 0;
    int last_key = 0;
    int lock_end = 0;

    function automatic void push_ev(int kind, int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        evq.push_back(e);
    endfunction

    // Expected level outputs from cycle c+1 on, assuming no further keys.
    function automatic void project(int c);
        for (int x = c + 1; x <= c + L + 2 && x < MAXC; x++) begin
            exp_active[x] = (mode == 1 || mode == 3) && (x - c <= T);
            exp_locked[x] = (mode == 2) && (x <= lock_end);
        end
    endfunction

    function automatic void advance(int t);
        if ((mode == 1 || mode == 3) && (t - last_key > T)) begin
            if (mode == 3) push_ev(3, last_key + T + 1);
            mode = 0;
            digs.delete();
        end
        if (mode == 2 && t > lock_end) begin
            mode  = 0;
            fails = 0;
        end
    endfunction

    function automatic bit is_cmd(int k);
        return (k == 10) || (k == 13) || (PCE && k == 11);
    endfunction

    function automatic bit pin_match();
        if (digs.size() != PIN_LEN) return 1'b0;
        for (int i = 0; i < PIN_LEN; i++)
            if (digs[i] != pin[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void wrong(int c);
        push_ev(3, c + 1);
        digs.delete();
        fails++;
        if (fails >= MAXF) begin
            mode     = 2;
            lock_end = c + L;
        end else begin
            mode = 0;
        end
    endfunction

    function automatic void model_key(int k, int c);
        advance(c);
        case (mode)
            0: begin
                if (k <= 9) begin
                    digs.delete(); digs.push_back(k); mode = 1; last_key = c; project(c);
                end else if (is_cmd(k)) begin
                    wrong(c); project(c);
                end
            end
            1: begin
                if (k <= 9) begin
                    digs.push_back(k); last_key = c; project(c);
                end else if (k == 12) begin
                    digs.delete(); mode = 0; project(c);
                end else if (is_cmd(k)) begin
                    if (pin_match()) begin
                        fails = 0;
                        digs.delete();
                        if (k == 11) begin
                            mode = 3; last_key = c;
                        end else begin
                            push_ev((k == 10) ? 1 : 2, c + 1); mode = 0;
                        end
                    end else begin
                        wrong(c);
                    end
                    project(c);
                end
            end
            3: begin
                if (k <= 9) begin
                    digs.push_back(k); last_key = c; project(c);
                end else if (k == 11) begin
                    if (digs.size() == PIN_LEN) pin = digs;
                    else push_ev(3, c + 1);
                    digs.delete(); mode = 0; project(c);
                end else if (k == 10 || k == 12 || k == 13) begin
                    push_ev(3, c + 1); digs.delete(); mode = 0; project(c);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset(int c);
        ev_t keep[$];
        mode = 0;
        digs.delete();
        fails = 0;
        pin.delete();
        pin.push_back(1); pin.push_back(2); pin.push_back(3); pin.push_back(4);
        for (int x = c + 1; x <= c + L + 2 && x < MAXC; x++) begin
            exp_active[x] = 1'b0;
            exp_locked[x] = 1'b0;
        end
        foreach (evq[i]) if (evq[i].cyc <= c) keep.push_back(evq[i]);
        evq = keep;
    endfunction

    task automatic idle(int n);
        advance(cyc + n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(int k, int gap);
        model_key(k, cyc);
        key_valid = 1'b1;
        key_code  = k[3:0];
        @(posedge clk); #1;
        key_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send5(int a, int b, int c, int d, int e, int gap);
        send(a, gap); send(b, gap); send(c, gap); send(d, gap); send(e, gap);
    endtask

    task automatic wait_unlock();
        if (mode == 2 && lock_end + 1 > cyc) idle(lock_end + 1 - cyc);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected events whenever the DUT presents a command or
    // bad_code pulse, and tracks the level outputs every cycle.
    int   mon_x;
    int   mon_k;
    ev_t  mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_x = cyc;
            while (evq.size() > 0 && evq[0].cyc < mon_x) begin
                mon_e = evq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d never seen, expected at cycle %0d", mon_e.kind, mon_e.cyc);
            end
            if (keypad != 4'b0000 || bad_code) begin
                if (keypad == 4'b0011 && !bad_code)      mon_k = 1;
                else if (keypad == 4'b1100 && !bad_code) mon_k = 2;
                else if (keypad == 4'b0000 && bad_code)  mon_k = 3;
                else                                     mon_k = 9;
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d (keypad=%b bad=%b) at cycle %0d, expected none", mon_k, keypad, bad_code, mon_x);
                end else begin
                    mon_e = evq.pop_front();
                    if (mon_e.kind != mon_k || mon_e.cyc != mon_x) begin
                        errors++;
                        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", mon_k, mon_x, mon_e.kind, mon_e.cyc);
                    end
                end
            end
            checks++;
            if (entry_active !== exp_active[mon_x]) begin
                errors++;
                $display("FAIL entry_active: got %b, expected %b at cycle %0d", entry_active, exp_active[mon_x], mon_x);
            end
            checks++;
            if (locked !== exp_locked[mon_x]) begin
                errors++;
                $display("FAIL locked: got %b, expected %b at cycle %0d", locked, exp_locked[mon_x], mon_x);
            end
        end
    end

    // Watchdog so the run always terminates.
    always @(posedge clk) begin
        if (cyc > MAXC - 2000) begin
            $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
            $fatal(1, "cycle budget exhausted");
        end
    end

    initial begin
        model_reset(0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("reset_keypad", keypad, 0);
        chk("reset_entry_active", entry_active, 0);
        chk("reset_locked", locked, 0);
        chk("reset_bad_code", bad_code, 0);
        model_reset(cyc);
        reset = 1'b0;
        idle(2);
        $display("TXN reset released at cycle %0d", cyc);

        // Correct PIN then arm, one key per three cycles.
        send5(1, 2, 3, 4, 10, 2);
        $display("TXN 1234 arm at cycle %0d", cyc);

        // Three wrong codes, lockout, keys ignored, then disarm.
        for (int i = 0; i < 3; i++) send5(1, 2, 3, 5, 13, 2);
        chk("lockout_entered", locked, 1);
        $display("TXN three wrong codes at cycle %0d", cyc);
        send5(1, 2, 3, 4, 10, 1);
        wait_unlock();
        chk("lockout_released", locked, 0);
        send5(1, 2, 3, 4, 13, 1);
        $display("TXN disarm after lockout at cycle %0d", cyc);

        // Timeout: T idle cycles expire the entry; a key exactly at the limit wins.
        send(1, 0); send(2, T);
        chk("timeout_entry_dropped", entry_active, 0);
        send(3, 0); send(4, 0); send(10, 3);
        $display("TXN timeout expired at cycle %0d", cyc);
        send(1, 0); send(2, T - 1);
        send(3, 0); send(4, 0); send(10, 3);
        $display("TXN key at timeout limit at cycle %0d", cyc);

        // Too many digits, then a clear before a good entry.
        send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 0); send(10, 3);
        send(1, 0); send(2, 0); send(12, 0);
        send5(1, 2, 3, 4, 10, 0);
        idle(3);
        $display("TXN overlong and clear at cycle %0d", cyc);

        // Reset in the middle of an entry.
        send(1, 0); send(2, 0); send(3, 2);
        reset = 1'b1;
        model_reset(cyc);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_keypad", keypad, 0);
        chk("midreset_entry_active", entry_active, 0);
        chk("midreset_bad_code", bad_code, 0);
        send(4, 0); send(10, 3);
        $display("TXN mid-entry reset at cycle %0d", cyc);

`ifdef KEYPAD_PIN_CHANGE_EN
        // PIN change, use of new PIN, old PIN rejected, reset restores.
        send5(1, 2, 3, 4, 11, 0);
        send5(9, 8, 7, 6, 11, 1);
        send5(9, 8, 7, 6, 10, 1);
        send5(1, 2, 3, 4, 10, 1);
        reset = 1'b1;
        model_reset(cyc);
        @(posedge clk); #1;
        reset = 1'b0;
        send5(1, 2, 3, 4, 10, 3);
        $display("TXN pin change at cycle %0d", cyc);
`endif

        // Random transactions.
        for (int t = 0; t < 30; t++) begin
            int r;
            int n;
            int cmd;
            int seq[$];
            wait_unlock();
            r = $urandom_range(0, 99);
            seq.delete();
            if (r < 55) begin
                seq = pin;
            end else if (r < 75) begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++) seq.push_back($urandom_range(0, 9));
            end else begin
                seq = pin;
                if ($urandom_range(0, 1) == 1) seq.push_back($urandom_range(0, 9));
                else seq[$urandom_range(0, PIN_LEN - 1)] = (seq[0] + 1) % 10;
            end
            if ($urandom_range(0, 9) == 0) seq.insert($urandom_range(0, seq.size()), 14 + $urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) seq.insert(0, 12);
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 10 : (r < 8) ? 13 : 11;
            seq.push_back(cmd);
            foreach (seq[i]) begin
                int gap;
                gap = ($urandom_range(0, 99) < 2) ? (T - 2 + $urandom_range(0, 2)) : $urandom_range(0, 3);
                send(seq[i], gap);
            end
            $display("TXN random %0d: %0d keys, cmd %0h at cycle %0d", t, seq.size(), cmd, cyc);
        end

        idle(T + 5);
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d expected events never seen, expected 0", evq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
